// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table for hex digits and scan-decoder state codes.
// The encoder and the decoder both use hex_glyph so the two ends agree on every pattern.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_HELD    = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  // Active-high segment pattern, bit order {g,f,e,d,c,b,a}
  function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nib);
    logic [SEG_W-1:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h58;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus snoop interface: the driver side presents seg/an, the decoder returns frames.
// Handshake: frame_valid is a one-cycle pulse with no back-pressure; value/err_mask hold until the next pulse.
interface seg7_scan_decoder_if #(
  parameter int DIGITS = 4
);
  import seg7_pkg::*;

  logic [SEG_W-1:0]    seg;
  logic [DIGITS-1:0]   an;
  logic [4*DIGITS-1:0] value;
  logic                frame_valid;
  logic [DIGITS-1:0]   err_mask;
  logic [1:0]          dbg_state;

  modport master (
    output seg, an,
    input  value, frame_valid, err_mask, dbg_state
  );

  modport slave (
    input  seg, an,
    output value, frame_valid, err_mask, dbg_state
  );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of a 7-segment pattern to its hex nibble.
// Anything outside the 16 hex glyphs, blank included, reports invalid with nibble 0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] i_pattern,
  output logic [3:0]       o_nibble,
  output logic             o_invalid
);

  always_comb begin
    o_nibble  = 4'h0;
    o_invalid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (i_pattern == hex_glyph(4'(k))) begin
        o_nibble  = 4'(k);
        o_invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers the displayed hex digits,
// accepting each digit only after a stable dwell and publishing complete frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int         SW      = DIGITS + SEG_W;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]       r_samp;
  logic [7:0]          r_stab_cnt;
  logic [1:0]          r_state;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_slot_val;
  logic [DIGITS-1:0]   r_slot_err;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_err_mask;

  logic [SW-1:0]       w_pins;
  logic [DIGITS-1:0]   w_slot;
  logic                w_changed;
  logic                w_inc;
  logic [7:0]          w_cnt_next;
  logic                w_capture;
  logic                w_complete;
  logic [3:0]          w_nibble;
  logic                w_invalid;
  logic [DIGITS-1:0]   w_seen_next;
  logic [4*DIGITS-1:0] w_val_merge;
  logic [DIGITS-1:0]   w_err_merge;

  seg7_glyph_decode u_decode (
    .i_pattern (~r_samp[SEG_W-1:0]),
    .o_nibble  (w_nibble),
    .o_invalid (w_invalid)
  );

  assign w_pins    = {bus.an, bus.seg};
  assign w_slot    = ~r_samp[SW-1:SEG_W];
  assign w_changed = (w_pins != r_samp);
  // Counting only continues while the held sample selects exactly one digit
  assign w_inc     = !w_changed && $onehot(w_slot);

  always_comb begin
    w_cnt_next = 8'd0;
    if (w_inc) begin
      w_cnt_next = (r_stab_cnt == CNT_MAX) ? CNT_MAX : r_stab_cnt + 8'd1;
    end
  end

  // Capture on the edge the counter reaches its threshold; HELD blocks repeat captures of one dwell
  assign w_capture   = w_inc && (w_cnt_next == CNT_HIT) && (r_state != ST_HELD);
  assign w_seen_next = r_seen | w_slot;
  assign w_complete  = w_capture && (&w_seen_next);

  always_comb begin
    w_val_merge = r_slot_val;
    w_err_merge = r_slot_err;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_slot[i]) begin
        w_val_merge[4*i +: 4] = w_nibble;
        w_err_merge[i]        = w_invalid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp     <= '1;
      r_stab_cnt <= 8'd0;
      r_state    <= ST_WAIT;
      r_seen     <= '0;
      r_slot_val <= '0;
      r_slot_err <= '0;
      r_value    <= '0;
      r_err_mask <= '0;
    end else begin
      r_samp     <= w_pins;
      r_stab_cnt <= w_cnt_next;
      if (w_complete) begin
        r_value    <= w_val_merge;
        r_err_mask <= w_err_merge;
        r_slot_val <= w_val_merge;
        r_seen     <= '0;
        r_slot_err <= '0;
        r_state    <= ST_PUBLISH;
      end else if (w_capture) begin
        r_slot_val <= w_val_merge;
        r_slot_err <= w_err_merge;
        r_seen     <= w_seen_next;
        r_state    <= ST_HELD;
      end else begin
        case (r_state)
          ST_HELD:    if (w_changed) r_state <= ST_WAIT;
          ST_PUBLISH: r_state <= ST_WAIT;
          default:    r_state <= ST_WAIT;
        endcase
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.err_mask    = r_err_mask;
  assign bus.frame_valid = (r_state == ST_PUBLISH);
  assign bus.dbg_state   = r_state;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Inverse of the team's hex-to-7-segment encoder. Snoops a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and recovers the hex digits being shown. Each digit slot is accepted only after its pattern has been stable for a programmable dwell. A complete multi-digit value is published with a one-cycle valid pulse and a per-digit error mask. Used in the lab test fixture to self-check display drivers and as a loopback monitor on the board.

## Interface

Parameters:
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (2..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg  in  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  in  DIGITS  active-low anode selects; an[i]=0 means digit i is driven.
- value  out  4*DIGITS  recovered digits; digit i at value[4i+3:4i].
- frame_valid  out  1  one-cycle pulse when value/err_mask are updated.
- err_mask  out  DIGITS  bit i set if digit i's accepted pattern was not a legal hex glyph.

## Operation

- Input stage: {an,seg} registered once into samp each cycle.
- Decode: pattern p = ~samp_seg matched against the hex glyph table 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,58,5E,79,71. A match yields the nibble. No match (including blank 00) yields nibble 0 with invalid=1.
- Select legality: samp_an must have exactly one zero bit. All-ones (blanking interval) or multiple zeros means no digit is selected. No capture occurs and the stability counter is held at 0.
- Stability counter stab_cnt (8 bit):
  - Cleared when samp differs from the previous samp.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - WAIT: when stab_cnt reaches STABLE_CYCLES-1 with a legal select, capture the digit → HELD.
  - HELD: the digit is already captured; stay until samp changes → WAIT. A long dwell captures only once.
  - PUBLISH: entered from the capture that completes all slots. Lasts one cycle, then → WAIT. A samp change during PUBLISH still clears stab_cnt.
- Capture of slot i:
  - slot_val[i] ← nibble; slot_err[i] ← invalid; seen[i] ← 1.
  - Recapturing a slot before the frame completes overwrites it (last accepted wins).
- Frame completion: when the capture makes seen all-ones, next state is PUBLISH. In PUBLISH:
  - value ← slot_val; err_mask ← slot_err; frame_valid=1.
  - seen and slot_err cleared.
- value and err_mask hold between frames.

## Timing

- Reset values: value=0, err_mask=0, frame_valid=0, state=WAIT, stab_cnt=0, seen=0, samp=all ones.
- Reset mid-frame discards partial slots; no frame_valid is issued for them.
- Latency: capture occurs STABLE_CYCLES cycles after {an,seg} first presents a new pattern at the pins (1 register plus STABLE_CYCLES-1 count).
- frame_valid is asserted the cycle after the completing capture, for exactly one cycle. value and err_mask become valid in that same cycle.
- Glitches shorter than STABLE_CYCLES cycles are never captured.
- A new frame may begin capturing on the cycle after PUBLISH.
- If a capture of a new slot is due during the PUBLISH cycle, it is taken and counted toward the next frame. seen is cleared first, then that slot is set.

## Structure

- Shared package/header seg7_pkg: the 16-entry glyph table (shared with the encoder so both ends agree), SEG_W=7, and state encodings.
- Sub-module seg7_glyph_decode: combinational pattern → {invalid, nibble} lookup. Instantiated once.
- Top module holds the sample register, stability counter, FSM, slot registers and output registers.

## Test plan

- Reset: assert rst async mid-clock → all outputs 0 immediately; hold 3 cycles, release → frame_valid stays 0 with idle an=all ones.
- Clean frame: DIGITS=4, STABLE_CYCLES=4, scan digits 0..3 showing 4,3,2,1, each held 8 cycles with 2 blank cycles between → one frame_valid pulse, value=16'h1234, err_mask=0.
- Glitch rejection: hold digit 0 showing 5 for only 3 cycles, then proceed → slot 0 not captured; frame_valid only after a subsequent 4+ cycle dwell on digit 0.
- Illegal glyph: digit 2 shows seg=7'b1111111 (blank) → value[11:8]=0, err_mask=4'b0100; the other digits decode correctly.
- Illegal select: an=4'b1100 with a valid pattern held for 20 cycles → no capture, seen unchanged, no frame_valid.
- Reset mid-frame plus overwrite: capture digits 0 and 1, pulse rst, then rescan all four with A,B,C,D, showing digit 0 twice with 9 then A → single frame, value=16'hDCBA.
